// File: rtl/mux_memoria_param.sv
// N_CH-to-1 registered mux with valid/ready handshake.
// Direct or round-robin channel selection, saturating word count.
module mux_memoria_param #(
  parameter int WIDTH = 2,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        selector,
  input  logic [N_CH*WIDTH-1:0]   data_in,
  input  logic [N_CH-1:0]         valid_in,
  output logic [N_CH-1:0]         ready_out,
  output logic [WIDTH-1:0]        data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [SEL_W-1:0]        grant_ch,
  output logic [CNT_W-1:0]        count
);

  localparam int PAD = 2**SEL_W;

  logic [PAD-1:0]   valid_pad;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] rr_cs;
  logic             rr_found;
  logic [SEL_W-1:0] cs;
  logic             chosen;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] word;
  int               idx;

  // Padding lets any selector value index safely; pad bits read as not valid.
  assign valid_pad = PAD'(valid_in);
  assign slot_free = !valid_out || ready_in;
  assign accept    = slot_free && chosen && valid_pad[cs];

  // Round-robin: first valid channel after the last granted one.
  always_comb begin
    rr_found = 1'b0;
    rr_cs    = '0;
    idx      = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last) + i) % N_CH;
      if (!rr_found && valid_pad[SEL_W'(idx)]) begin
        rr_found = 1'b1;
        rr_cs    = SEL_W'(idx);
      end
    end
  end

  // Chosen channel; out-of-range selectors choose nothing.
  always_comb begin
    cs     = selector;
    chosen = ({1'b0, selector} < (SEL_W+1)'(N_CH));
    if (mode) begin
      cs     = rr_cs;
      chosen = rr_found;
    end
  end

  // Data mux and one-hot acceptance strobe.
  always_comb begin
    word      = '0;
    ready_out = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (SEL_W'(c) == cs) begin
        word         = data_in[c*WIDTH +: WIDTH];
        ready_out[c] = accept;
      end
    end
  end

  // Output register, counter and rr pointer.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      grant_ch  <= '0;
      count     <= '0;
      last      <= SEL_W'(N_CH-1);
    end else begin
      if (accept) begin
        data_out  <= word;
        grant_ch  <= cs;
        valid_out <= 1'b1;
        if (count != '1)
          count <= count + 1'b1;
        if (mode)
          last <= cs;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
